// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, holding register and sticky error flags
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_read,
  input  logic       err_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  // Start-bit validation point; derived, not meant to be overridden.
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Decoded counter terminal points, shared by next-state and output logic.
  logic half_hit;
  logic bit_end;

  // Per-cycle control strobes from the output process.
  logic cnt_clear;
  logic bit_sample;
  logic stop_good;
  logic stop_bad;

  assign half_hit = (cnt == CNT_HALF_LAST);
  assign bit_end  = (cnt == CNT_BIT_LAST);

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      sync_meta <= rx_in;
      rx_sync   <= sync_meta;
    end
  end

  // State register; busy is registered alongside so it tracks the state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      rx_busy <= (state_next != IDLE);
    end
  end

  // Next-state decision, driven only by the synchronized line and the counters.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_sync) state_next = START;
      end
      START: begin
        if (half_hit) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = rx_sync ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: counter control and the datapath strobes for each state.
  always_comb begin
    cnt_clear  = 1'b0;
    bit_sample = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE:      cnt_clear = 1'b1;
      START:     cnt_clear = half_hit;
      DATA: begin
        cnt_clear  = bit_end;
        bit_sample = bit_end;
      end
      STOP: begin
        cnt_clear = bit_end;
        stop_good = bit_end && rx_sync;
        stop_bad  = bit_end && !rx_sync;
      end
      WAIT_HIGH: cnt_clear = 1'b1;
      default:   cnt_clear = 1'b1;
    endcase
  end

  // Bit-timing counter and data-bit index; the index restarts on every accepted start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else begin
      if (cnt_clear) cnt <= '0;
      else           cnt <= cnt + CNT_ONE;

      if (state == START)  bit_idx <= 3'd0;
      else if (bit_sample) bit_idx <= bit_idx + 3'd1;
    end
  end

  // Assembly register, kept apart from rx_data so a bad frame never disturbs the held byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift <= 8'h00;
    end else if (bit_sample) begin
      shift[bit_idx] <= rx_sync;
    end
  end

  // Host-side holding register and sticky flags; a new error wins over err_clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (stop_good) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end

      if (stop_bad)       frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;

      if (stop_good && rx_valid && !rx_read) overrun_err <= 1'b1;
      else if (err_clear)                    overrun_err <= 1'b0;
    end
  end

endmodule
